// File: rtl/jerky_counter_pkg.sv
`default_nettype none
// ============================================================================
// Module   : jerky_counter_pkg
// Purpose  : Shared constants, state encoding and step values for the
//            jerky_counter pattern generator.
// Contents : COUNT_W, state_t, STEP_* signed step constants.
// Revision : 1.0 - initial release
// ============================================================================
package jerky_counter_pkg;

  localparam int COUNT_W = 8;

  // Five reachable states; encodings 5..7 are unreachable and recover to S_INC1.
  typedef enum logic [2:0] {
    S_INC1  = 3'd0,
    S_INC2  = 3'd1,
    S_STALL = 3'd2,
    S_JUMP  = 3'd3,
    S_BACK  = 3'd4
  } state_t;

  localparam logic signed [COUNT_W-1:0] STEP_INC   = 8'sd1;
  localparam logic signed [COUNT_W-1:0] STEP_STALL = 8'sd0;
  localparam logic signed [COUNT_W-1:0] STEP_JUMP  = 8'sd4;
  localparam logic signed [COUNT_W-1:0] STEP_BACK  = -8'sd2;

endpackage : jerky_counter_pkg
`default_nettype wire

// File: rtl/jerky_step_decode.sv
`default_nettype none
// ============================================================================
// Module   : jerky_step_decode
// Purpose  : Combinational decode of the current FSM state into the signed
//            step to add to the count and the following state.
// Ports    : state      in  state_t            current state
//            step       out signed [COUNT_W-1:0] step for this edge
//            state_next out state_t            state after this edge
// Revision : 1.0 - initial release
// ============================================================================
module jerky_step_decode
  import jerky_counter_pkg::*;
(
  input  state_t                      state,
  output logic signed [COUNT_W-1:0]   step,
  output state_t                      state_next
);

  always_comb begin
    // Defaults also cover the unreachable encodings: hold count, go to S_INC1.
    step       = STEP_STALL;
    state_next = S_INC1;
    case (state)
      S_INC1: begin
        step       = STEP_INC;
        state_next = S_INC2;
      end
      S_INC2: begin
        step       = STEP_INC;
        state_next = S_STALL;
      end
      S_STALL: begin
        step       = STEP_STALL;
        state_next = S_JUMP;
      end
      S_JUMP: begin
        step       = STEP_JUMP;
        state_next = S_BACK;
      end
      S_BACK: begin
        step       = STEP_BACK;
        state_next = S_INC1;
      end
      default: begin
        step       = STEP_STALL;
        state_next = S_INC1;
      end
    endcase
  end

endmodule : jerky_step_decode
`default_nettype wire

// File: rtl/jerky_counter.sv
`default_nettype none
// ============================================================================
// Module   : jerky_counter
// Purpose  : Free-running 8-bit counter advancing +1,+1,0,+4,-2 repeatedly
//            (net +4 every 5 clocks, full period 320 clocks).
// Ports    : clock in  1        rising-edge clock
//            reset in  1        asynchronous active-low reset
//            count out COUNT_W  current count, straight from a register
// Revision : 1.0 - initial release
// ============================================================================
module jerky_counter
  import jerky_counter_pkg::*;
(
  input  logic               clock,
  input  logic               reset,
  output logic [COUNT_W-1:0] count
);

  state_t                     state_q;
  state_t                     state_d;
  logic [COUNT_W-1:0]         count_q;
  logic [COUNT_W-1:0]         count_d;
  logic signed [COUNT_W-1:0]  step;

  jerky_step_decode u_step_decode (
    .state      (state_q),
    .step       (step),
    .state_next (state_d)
  );

  // Two's-complement step added at full width wraps modulo 256 both ways.
  always_comb begin
    count_d = count_q + $unsigned(step);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= S_INC1;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule : jerky_counter
`default_nettype wire

// File: tb/tb_jerky_counter.sv
`default_nettype none
// ============================================================================
// Module   : tb_jerky_counter
// Purpose  : Self-checking bench for jerky_counter. Stimulus drives reset and
//            pushes the expected count for each upcoming falling edge; a
//            monitor pops and compares on every falling edge.
// Revision : 1.0 - initial release
// ============================================================================
module tb_jerky_counter;

  logic       clock;
  logic       reset;
  logic [7:0] count;

  int checks = 0;
  int errors = 0;

  int exp_q[$];
  int tag_q[$];

  // Edges since the last reset release.
  int n = 0;

  jerky_counter dut (
    .clock (clock),
    .reset (reset),
    .count (count)
  );

  initial begin
    clock = 1'b0;
    forever #20 clock = ~clock;
  end

  // Reference: each 5-edge cycle nets +4; within a cycle the partial sums of
  // the step pattern (+1,+1,0,+4,-2) are 0,1,2,2,6.
  function automatic int ref_count(input int edges);
    int off[5];
    off = '{0, 1, 2, 2, 6};
    return (4 * (edges / 5) + off[edges % 5]) % 256;
  endfunction

  task automatic push_exp(input int e);
    exp_q.push_back(e);
    tag_q.push_back(n);
  endtask

  // Called just after a rising edge. Sets up one clock period of stimulus and
  // the expectation for the falling edge inside it.
  task automatic run_cycle(input bit rst_lvl, input bit pulse);
    if (pulse) begin
      push_exp(0);
      #4 reset = 1'b0;
      n = 0;
      #20 reset = 1'b1;     // low across the falling edge, released before next rise
    end else begin
      reset = rst_lvl;
      if (!rst_lvl) n = 0;
      push_exp(rst_lvl ? ref_count(n) : 0);
    end
    @(posedge clock);
    if (reset) n = n + 1;
    else       n = 0;
    #1;
  endtask

  task automatic run_to_phase(input int ph);
    for (int i = 0; i < 5 && (n % 5) != ph; i++) run_cycle(1'b1, 1'b0);
  endtask

  // Monitor: the count is presented every clock; compare on falling edges.
  initial begin
    forever begin
      @(negedge clock);
      if (exp_q.size() != 0) begin
        int e;
        int t;
        e = exp_q.pop_front();
        t = tag_q.pop_front();
        checks++;
        if (int'(count) != e) begin
          errors++;
          $display("FAIL count edges=%0d actual=%0d expected=%0d", t, count, e);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog timeout actual=running expected=finished");
    $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
    $fatal(1);
  end

  initial begin
    reset = 1'b0;
    @(posedge clock);
    #1;
    // Power-up reset held over two edges.
    run_cycle(1'b0, 1'b0);
    run_cycle(1'b0, 1'b0);
    // Release and run beyond a full period (covers k = 1..63 and wrap).
    for (int i = 0; i < 330; i++) run_cycle(1'b1, 1'b0);

    // Mid-run asynchronous pulse after 73 edges.
    run_cycle(1'b0, 1'b0);
    for (int i = 0; i < 73; i++) run_cycle(1'b1, 1'b0);
    run_cycle(1'b1, 1'b1);
    for (int i = 0; i < 12; i++) run_cycle(1'b1, 1'b0);

    // Reset in S_STALL, S_JUMP, S_BACK (phases 2,3,4), alternately as a
    // short pulse and as a level held over several edges.
    for (int ph = 2; ph <= 4; ph++) begin
      for (int i = 0; i < 7; i++) run_cycle(1'b1, 1'b0);
      run_to_phase(ph);
      run_cycle(1'b1, 1'b1);
      for (int i = 0; i < 11; i++) run_cycle(1'b1, 1'b0);
      run_to_phase(ph);
      for (int i = 0; i < 3; i++) run_cycle(1'b0, 1'b0);
      for (int i = 0; i < 11; i++) run_cycle(1'b1, 1'b0);
    end

    // Randomized reset activity.
    for (int i = 0; i < 400; i++) begin
      int r;
      r = $urandom_range(0, 29);
      if (r == 0)      run_cycle(1'b1, 1'b1);
      else if (r <= 2) run_cycle(1'b0, 1'b0);
      else             run_cycle(1'b1, 1'b0);
    end

    @(negedge clock);
    @(negedge clock);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain actual=%0d expected=0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_jerky_counter
`default_nettype wire

// File: doc/jerky_counter.md
# jerky_counter

Free-running 8-bit counter that advances in a deliberately irregular ("jerky") pattern: two single steps, a stall, a jump forward and a partial step back, repeated forever. A five-state Moore FSM selects a signed step that is added to the count register every clock. It is a standalone demo/pattern-generator block with no handshake: it runs from reset and its only output is the current count.

## Interface
- Parameters: none. Width is fixed at 8 bits via the package constant `COUNT_W = 8`.
- `clock`  input  1  Single clock; all state changes on its rising edge.
- `reset`  input  1  Asynchronous, active-low reset (0 = reset).
- `count`  output 8  Current counter value, driven directly from a register.

## Operation
- FSM states, in order: `S_INC1`, `S_INC2`, `S_STALL`, `S_JUMP`, `S_BACK`.
- Step applied on the clock edge, by current state:
  - `S_INC1`: +1, then go to `S_INC2`.
  - `S_INC2`: +1, then go to `S_STALL`.
  - `S_STALL`: +0 (hold), then go to `S_JUMP`.
  - `S_JUMP`: +4, then go to `S_BACK`.
  - `S_BACK`: −2, then go to `S_INC1`.
- Net progress is +4 per 5 clocks. With `k` full cycles since reset (5·k edges), `count = (4·k) mod 256` and the state is `S_INC1`.
- Arithmetic is unsigned modulo 256 in both directions. Overflow wraps (252 → 253, 254, 254, 2, 0). Underflow also wraps modulo 256, though the sequence from reset never underflows.
- Full period: 320 clocks, after which `count` is 0 and the state is `S_INC1`.
- The state register must be an enum with all unreachable encodings recovering to `S_INC1`, with `count` unchanged on that recovery edge.

## Timing
- Reset asserted (`reset` = 0): `count` = 8'h00 and state = `S_INC1` immediately, without waiting for a clock edge. This holds for the whole time reset is low.
- Reset mid-operation: the same behaviour applies, whatever the current state or count.
- Reset release: the first rising edge with `reset` = 1 produces `count` = 1. The sequence from reset is 0, 1, 2, 2, 6, 4, 5, 6, 6, 10, 8, …
- Latency: `count` updates exactly one clock edge after the state that selects the step. There are no combinational paths from inputs to `count`.
- Before the first reset, `count` is undefined. The system must apply reset at power-up.

## Structure
- Package `jerky_counter_pkg` holds:
  - `COUNT_W`;
  - the `typedef enum logic [2:0] state_t` with the five states;
  - signed step constants `STEP_INC = 1`, `STEP_STALL = 0`, `STEP_JUMP = 4`, `STEP_BACK = -2`.
- One natural sub-module, `jerky_step_decode`: combinational, maps `state_t` to a signed step and the next state.
- The top level holds the state register, the count register and the modulo-256 adder.

## Test plan
- Power-up reset: hold `reset` = 0 for 2 clocks → `count` = 0. Release → the next 10 edges give 1, 2, 2, 6, 4, 5, 6, 6, 10, 8.
- Long run: 5·k edges after release for k = 1..63 → `count` = 4·k each time.
- Wrap-around: edges 316–320 after release → 253, 254, 254, 2, 0. Then the sequence repeats 1, 2, 2, 6, 4.
- Mid-run asynchronous reset: after 73 edges, pulse `reset` low for 20 ns between edges → `count` = 0 immediately. The first edge after release gives 1.
- Reset during each state: assert reset while in `S_STALL`, `S_JUMP` and `S_BACK` in turn → `count` = 0 each time, and the restart sequence is identical to the power-up sequence.
- Reset held across several clock edges → `count` stays 0 and no step is applied.
